// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect definitions: BRESP codes, write-response FSM state encoding
// and a saturating counter helper.
package axi_ic_pkg;

    typedef logic [1:0] bresp_t;

    localparam bresp_t OKAY   = 2'b00;
    localparam bresp_t EXOKAY = 2'b01;
    localparam bresp_t SLVERR = 2'b10;
    localparam bresp_t DECERR = 2'b11;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    // SLVERR and DECERR both carry bit 1 set; OKAY/EXOKAY do not.
    function automatic logic resp_is_err(input bresp_t resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/rr_arb_2.sv
// Two-request round-robin arbiter: a lone request always wins, a tie goes to the
// requester selected by ptr. The pointer itself is owned by the parent.
module rr_arb_2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/write_resp_channel_arb.sv
// Round-robin arbiter for B responses from two slave ports into a one-entry output register.
// Define WRESP_ERR_CNT_EN to add the saturating Err_Count of SLVERR/DECERR handshakes.
module write_resp_channel_arb
    import axi_ic_pkg::*;
#(
    parameter int Num_Of_Masters  = 2,
    parameter int Master_ID_Width = $clog2(Num_Of_Masters)
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       M00_AXI_bvalid,
    input  logic [1:0]                 M00_AXI_bresp,
    input  logic [Master_ID_Width-1:0] M00_AXI_bid,
    output logic                       M00_AXI_bready,
    input  logic                       M01_AXI_bvalid,
    input  logic [1:0]                 M01_AXI_bresp,
    input  logic [Master_ID_Width-1:0] M01_AXI_bid,
    output logic                       M01_AXI_bready,
    output logic [Master_ID_Width-1:0] Sel_Resp_ID,
    output logic                       Sel_Valid,
    output logic [1:0]                 Sel_Write_Resp,
    input  logic                       Sel_Ready
`ifdef WRESP_ERR_CNT_EN
    ,
    output logic [15:0]                Err_Count
`endif
);

    logic [0:0] state;
    logic       ptr;
    logic       load;
    logic [1:0] req;
    logic [1:0] gnt;

    // The register can take a new response when empty or when its current one is leaving.
    assign load = (state == IDLE) | ((state == HOLD) & Sel_Ready);
    assign req  = {M01_AXI_bvalid, M00_AXI_bvalid};

    rr_arb_2 u_arb (
        .req (req),
        .ptr (ptr),
        .en  (load),
        .gnt (gnt)
    );

    assign M00_AXI_bready = gnt[0];
    assign M01_AXI_bready = gnt[1];
    assign Sel_Valid      = (state == HOLD);

    // The pointer moves to the losing slave so a continuously valid pair alternates.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state          <= IDLE;
            ptr            <= 1'b0;
            Sel_Resp_ID    <= '0;
            Sel_Write_Resp <= OKAY;
        end else if (|gnt) begin
            state <= HOLD;
            ptr   <= gnt[0];
            if (gnt[1]) begin
                Sel_Resp_ID    <= M01_AXI_bid;
                Sel_Write_Resp <= M01_AXI_bresp;
            end else begin
                Sel_Resp_ID    <= M00_AXI_bid;
                Sel_Write_Resp <= M00_AXI_bresp;
            end
        end else if (load) begin
            state <= IDLE;
        end
    end

`ifdef WRESP_ERR_CNT_EN
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            Err_Count <= 16'd0;
        end else if (Sel_Valid & Sel_Ready & resp_is_err(Sel_Write_Resp)) begin
            Err_Count <= sat_inc16(Err_Count);
        end
    end
`endif

endmodule

// File: tb/tb_write_resp_channel_arb.sv
// Randomized scoreboard bench for write_resp_channel_arb: a transaction-level model predicts
// grants and queues expected responses; a monitor compares them as the DUT presents them.
module tb_write_resp_channel_arb;

    localparam int MW = 1;

    logic          aclk   = 1'b0;
    logic          areset = 1'b0;
    logic          m00_bvalid, m01_bvalid;
    logic [1:0]    m00_bresp, m01_bresp;
    logic [MW-1:0] m00_bid, m01_bid;
    logic          m00_bready, m01_bready;
    logic [MW-1:0] sel_resp_id;
    logic          sel_valid;
    logic [1:0]    sel_write_resp;
    logic          sel_ready;
`ifdef WRESP_ERR_CNT_EN
    logic [15:0]   err_count;
`endif

    int errors = 0;
    int checks = 0;

    // Expected responses, oldest first, packed as {id, resp}.
    logic [MW+1:0] exp_q[$];
    int            m_full = 0;
    int            m_ptr  = 0;
    logic [1:0]    m_held_resp = 2'b00;
    int            m_err  = 0;

    always #5 aclk = ~aclk;

    write_resp_channel_arb #(.Num_Of_Masters(2), .Master_ID_Width(MW)) dut (
        .ACLK           (aclk),
        .ARESET         (areset),
        .M00_AXI_bvalid (m00_bvalid),
        .M00_AXI_bresp  (m00_bresp),
        .M00_AXI_bid    (m00_bid),
        .M00_AXI_bready (m00_bready),
        .M01_AXI_bvalid (m01_bvalid),
        .M01_AXI_bresp  (m01_bresp),
        .M01_AXI_bid    (m01_bid),
        .M01_AXI_bready (m01_bready),
        .Sel_Resp_ID    (sel_resp_id),
        .Sel_Valid      (sel_valid),
        .Sel_Write_Resp (sel_write_resp),
        .Sel_Ready      (sel_ready)
`ifdef WRESP_ERR_CNT_EN
        ,
        .Err_Count      (err_count)
`endif
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // One cycle of stimulus, called just after a falling edge; returns the predicted winner (-1 none).
    task automatic apply_stimulus(input logic v0, input logic [MW-1:0] id0, input logic [1:0] r0,
                                  input logic v1, input logic [MW-1:0] id1, input logic [1:0] r1,
                                  input logic rdy, output int won);
        int w;
        int load;
        m00_bvalid = v0; m00_bid = id0; m00_bresp = r0;
        m01_bvalid = v1; m01_bid = id1; m01_bresp = r1;
        sel_ready  = rdy;
        #1;
        load = (m_full == 0 || rdy) ? 1 : 0;
        w = -1;
        if (load != 0 && (v0 || v1))
            w = (v0 && v1) ? m_ptr : (v1 ? 1 : 0);
        check_output("sel_valid", {31'd0, sel_valid}, m_full);
        check_output("m00_bready", {31'd0, m00_bready}, (w == 0) ? 1 : 0);
        check_output("m01_bready", {31'd0, m01_bready}, (w == 1) ? 1 : 0);
`ifdef WRESP_ERR_CNT_EN
        check_output("err_count", {16'd0, err_count}, m_err);
`endif
        if (m_full != 0 && rdy && m_held_resp[1] && m_err < 65535)
            m_err++;
        if (w >= 0) begin
            exp_q.push_back((w == 1) ? {id1, r1} : {id0, r0});
            m_full      = 1;
            m_held_resp = (w == 1) ? r1 : r0;
            m_ptr       = 1 - w;
        end else if (load != 0) begin
            m_full = 0;
        end
        won = w;
        @(negedge aclk);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        m00_bvalid = 1'b0; m01_bvalid = 1'b0; sel_ready = 1'b0;
        m00_bid = '0; m01_bid = '0; m00_bresp = 2'b00; m01_bresp = 2'b00;
        #1;
        check_output("rst_sel_valid", {31'd0, sel_valid}, 0);
        check_output("rst_sel_id", {31'd0, sel_resp_id}, 0);
        check_output("rst_sel_resp", {30'd0, sel_write_resp}, 0);
`ifdef WRESP_ERR_CNT_EN
        check_output("rst_err_count", {16'd0, err_count}, 0);
`endif
        exp_q.delete();
        m_full = 0; m_ptr = 0; m_err = 0; m_held_resp = 2'b00;
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
    endtask

    // Scoreboard monitor: whatever the DUT presents must be the oldest outstanding response.
    always begin
        @(negedge aclk);
        #3;
        if (!areset && sel_valid) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_valid", {31'd0, sel_valid}, 0);
            end else begin
                check_output("sel_id", {31'd0, sel_resp_id}, {31'd0, exp_q[0][MW+1:2]});
                check_output("sel_resp", {30'd0, sel_write_resp}, {30'd0, exp_q[0][1:0]});
                if (sel_ready)
                    void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int won;
        logic          pv0, pv1;
        logic [MW-1:0] pid0, pid1;
        logic [1:0]    pr0, pr1;

        do_reset();

        // Single response from slave 0, accepted immediately.
        apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, won);
        apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, won);
        apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, won);

        // Slave 1 SLVERR held under backpressure while a second response waits.
        apply_stimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, won);
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0, won);
        apply_stimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b11, 1'b1, won);
        apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, won);
        apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, won);

        // Fairness with both slaves continuously valid after reset.
        do_reset();
        for (int i = 0; i < 4; i++)
            apply_stimulus(1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 1'b1, won);
        apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, won);

        // Asynchronous reset while holding a response, then priority back at slave 0.
        do_reset();
        apply_stimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b11, 1'b0, won);
        do_reset();
        apply_stimulus(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 2'b01, 1'b1, won);
        apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, won);
        apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, won);

        // Randomized traffic; each slave holds bvalid until the model says it was popped.
        pv0 = 1'b0; pv1 = 1'b0; pid0 = '0; pid1 = '0; pr0 = 2'b00; pr1 = 2'b00;
        for (int c = 0; c < 400; c++) begin
            if (!pv0 && $urandom_range(0, 9) < 6) begin
                pv0 = 1'b1; pid0 = MW'($urandom_range(0, 1)); pr0 = 2'($urandom_range(0, 3));
            end
            if (!pv1 && $urandom_range(0, 9) < 6) begin
                pv1 = 1'b1; pid1 = MW'($urandom_range(0, 1)); pr1 = 2'($urandom_range(0, 3));
            end
            apply_stimulus(pv0, pid0, pr0, pv1, pid1, pr1, $urandom_range(0, 3) != 0, won);
            if (won == 0) pv0 = 1'b0;
            if (won == 1) pv1 = 1'b0;
        end
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, won);
        check_output("drain_queue_empty", exp_q.size(), 0);
        check_output("drain_sel_valid", {31'd0, sel_valid}, 0);

`ifdef WRESP_ERR_CNT_EN
        // Error counting over OKAY, SLVERR, DECERR, EXOKAY, then saturation.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, won);
        apply_stimulus(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b1, won);
        apply_stimulus(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b1, won);
        apply_stimulus(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, won);
        apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, won);
        apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, won);
        check_output("err_after_seq", {16'd0, err_count}, 2);
        for (int i = 0; i < 65540; i++)
            apply_stimulus(1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 2'b11, 1'b1, won);
        apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, won);
        apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, won);
        check_output("err_saturated", {16'd0, err_count}, 32'h0000FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
